// File: rtl/scpad_req_arb.sv
// Round-robin arbiter funnelling N_REQ requesters into one registered scratchpad
// request port, with an outstanding-request credit counter and an underflow flag.
module scpad_req_arb #(
   parameter  int N_REQ   = 4,
   parameter  int REQ_W   = 64,
   parameter  int MAX_OUT = 4,
   localparam int CNT_W   = $clog2(MAX_OUT + 1),
   localparam int SRC_W   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*REQ_W-1:0] req_data,
   output logic [N_REQ-1:0]       req_stall,
   output logic                   out_valid,
   output logic [REQ_W-1:0]       out_req,
   output logic [SRC_W-1:0]       out_src,
   input  logic                   ds_stall,
   input  logic                   resp_done,
   output logic [CNT_W-1:0]       inflight,
   output logic                   busy,
   output logic                   err_underflow
);

   logic             out_valid_q, out_valid_d;
   logic [REQ_W-1:0] out_req_q, out_req_d;
   logic [SRC_W-1:0] out_src_q, out_src_d;
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic             err_q, err_d;

   logic             slot_free, can_grant, grant_vld, dec;
   logic [SRC_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant;

   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return SRC_W'(s);
   endfunction

   // Credit check uses the registered count only, so a completion never frees
   // a slot in the cycle it arrives.
   assign slot_free = !out_valid_q || !ds_stall;
   assign can_grant = n_rst && slot_free && (inflight_q < CNT_W'(MAX_OUT));

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant     = '0;
      if (can_grant) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_valid[wrap_add(rr_ptr_q, k)]) begin
               grant_vld = 1'b1;
               grant_idx = wrap_add(rr_ptr_q, k);
            end
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   assign req_stall = req_valid & ~grant;

   always_comb begin
      out_valid_d = out_valid_q;
      out_req_d   = out_req_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant_vld) begin
         out_valid_d = 1'b1;
         out_req_d   = req_data[int'(grant_idx)*REQ_W +: REQ_W];
         out_src_d   = grant_idx;
         rr_ptr_d    = wrap_add(grant_idx, 1);
      end else if (out_valid_q && !ds_stall) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      dec        = resp_done && (inflight_q != '0);
      inflight_d = inflight_q;
      err_d      = err_q || (resp_done && (inflight_q == '0));
      case ({grant_vld, dec})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         out_valid_q <= 1'b0;
         out_req_q   <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
         inflight_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_req_q   <= out_req_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_req       = out_req_q;
   assign out_src       = out_src_q;
   assign inflight      = inflight_q;
   assign busy          = out_valid_q || (inflight_q != '0);
   assign err_underflow = err_q;

endmodule

// File: tb/tb_scpad_req_arb.sv
// Scoreboard bench for scpad_req_arb: directed stimulus queues expected (src, data)
// pairs; a monitor pops one each time the DUT output is consumed.
module tb_scpad_req_arb;
   localparam int N_REQ = 4, REQ_W = 64, MAX_OUT = 4, CNT_W = 3, SRC_W = 2;

   logic                   clk = 1'b0;
   logic                   n_rst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*REQ_W-1:0] req_data;
   logic [N_REQ-1:0]       req_stall;
   logic                   out_valid;
   logic [REQ_W-1:0]       out_req;
   logic [SRC_W-1:0]       out_src;
   logic                   ds_stall;
   logic                   resp_done;
   logic [CNT_W-1:0]       inflight;
   logic                   busy;
   logic                   err_underflow;

   logic [REQ_W-1:0] dat [N_REQ];

   typedef struct packed {
      logic [SRC_W-1:0] src;
      logic [REQ_W-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   scpad_req_arb #(.N_REQ(N_REQ), .REQ_W(REQ_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data(req_data),
      .req_stall(req_stall), .out_valid(out_valid), .out_req(out_req),
      .out_src(out_src), .ds_stall(ds_stall), .resp_done(resp_done),
      .inflight(inflight), .busy(busy), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N_REQ; i++) req_data[i*REQ_W +: REQ_W] = dat[i];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] ph);
      for (int i = 0; i < N_REQ; i++)
         dat[i] = {16'hCAFE, ph, 8'(i), 32'h1234_5678 ^ {24'h0, ph}};
   endtask

   task automatic push(input int i);
      exp_q.push_back({SRC_W'(i), dat[i]});
   endtask

   // Monitor: a request leaves the output register on an edge where out_valid=1 and ds_stall=0
   always @(negedge clk) begin
      if (n_rst === 1'b1 && out_valid === 1'b1 && ds_stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL mon_unexpected: got src %0d with no expected entry", out_src);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_src", 64'(out_src), 64'(e.src));
            check("mon_data", out_req, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_data(8'h00);
      n_rst = 1'b0; req_valid = '0; ds_stall = 1'b0; resp_done = 1'b0;
      step(); step();

      // reset state, every valid requester stalled
      req_valid = 4'b1111; #1;
      check("rst_stall", 64'(req_stall), 64'hF);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_out_src", 64'(out_src), 0);
      check("rst_out_req", out_req, 0);
      check("rst_inflight", 64'(inflight), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_err", 64'(err_underflow), 0);
      step();

      // continuous round robin with resp_done echoing each grant
      n_rst = 1'b1; #1;
      check("rr_stall0", 64'(req_stall), 64'hE);
      push(0);
      step();
      check("rr_inflight1", 64'(inflight), 1);
      resp_done = 1'b1;
      for (int g = 1; g < 8; g++) begin
         #1;
         check("rr_stall", 64'(req_stall), 64'(4'hF & ~(4'b0001 << (g % 4))));
         push(g % 4);
         step();
      end
      check("rr_inflight_steady", 64'(inflight), 1);
      req_valid = '0;
      step();
      resp_done = 1'b0;
      check("rr_inflight_end", 64'(inflight), 0);
      check("rr_out_valid_end", 64'(out_valid), 0);
      check("rr_busy_end", 64'(busy), 0);

      // sparse valid 1010 starting from rr_ptr=2
      set_data(8'h01);
      req_valid = 4'b0010; #1;
      check("sp_stall_pre", 64'(req_stall), 0);
      push(1); step();
      req_valid = 4'b1010; #1;
      check("sp_stall_a", 64'(req_stall), 64'h2);
      push(3); step(); #1;
      check("sp_stall_b", 64'(req_stall), 64'h8);
      push(1); step(); #1;
      check("sp_stall_c", 64'(req_stall), 64'h2);
      push(3); step(); #1;
      check("sp_full_stall", 64'(req_stall), 64'hA);
      check("sp_inflight4", 64'(inflight), 4);
      req_valid = '0; resp_done = 1'b1;
      repeat (4) step();
      resp_done = 1'b0;
      check("sp_drained", 64'(inflight), 0);

      // downstream stall holds the output register
      set_data(8'h02);
      req_valid = 4'b1111; #1;
      check("ds_stall_pre", 64'(req_stall), 64'hE);
      push(0); step();
      ds_stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("ds_hold_valid", 64'(out_valid), 1);
         check("ds_hold_src", 64'(out_src), 0);
         check("ds_hold_req", out_req, dat[0]);
         check("ds_hold_stall", 64'(req_stall), 64'hF);
         step();
      end
      ds_stall = 1'b0; #1;
      check("ds_release_stall", 64'(req_stall), 64'hD);
      push(1); step();
      check("ds_cont_valid", 64'(out_valid), 1);
      check("ds_cont_src", 64'(out_src), 1);
      check("ds_inflight2", 64'(inflight), 2);
      req_valid = '0;
      step();

      // grant and completion together, then underflow
      req_valid = 4'b0100; resp_done = 1'b1; #1;
      check("sim_stall", 64'(req_stall), 0);
      push(2); step();
      check("sim_inflight", 64'(inflight), 2);
      req_valid = '0;
      step(); step();
      check("uf_pre_inflight", 64'(inflight), 0);
      check("uf_pre_err", 64'(err_underflow), 0);
      step();
      resp_done = 1'b0;
      check("uf_inflight", 64'(inflight), 0);
      check("uf_err", 64'(err_underflow), 1);
      step(); step();
      check("uf_sticky", 64'(err_underflow), 1);

      // credit limit: no same-cycle forwarding of a completion
      set_data(8'h03);
      req_valid = 4'b1111; #1;
      check("cr_stall3", 64'(req_stall), 64'h7);
      push(3); step(); #1;
      check("cr_stall0", 64'(req_stall), 64'hE);
      push(0); step(); #1;
      check("cr_stall1", 64'(req_stall), 64'hD);
      push(1); step(); #1;
      check("cr_stall2", 64'(req_stall), 64'hB);
      push(2); step(); #1;
      check("cr_inflight4", 64'(inflight), 4);
      check("cr_full_stall", 64'(req_stall), 64'hF);
      resp_done = 1'b1; #1;
      check("cr_no_forward", 64'(req_stall), 64'hF);
      step();
      resp_done = 1'b0; #1;
      check("cr_inflight3", 64'(inflight), 3);
      check("cr_regrant_stall", 64'(req_stall), 64'h7);
      push(3); step();
      check("cr_inflight4b", 64'(inflight), 4);
      req_valid = '0;
      step();
      resp_done = 1'b1;
      repeat (4) step();
      resp_done = 1'b0;
      check("cr_drained", 64'(inflight), 0);
      check("cr_busy", 64'(busy), 0);

      // reset mid-operation drops the held request and credits
      set_data(8'h04);
      req_valid = 4'b1111;
      push(0); step();
      push(1); step();
      step();
      ds_stall = 1'b1; #1;
      check("mr_held_valid", 64'(out_valid), 1);
      check("mr_held_src", 64'(out_src), 2);
      check("mr_inflight3", 64'(inflight), 3);
      n_rst = 1'b0; #1;
      check("mr_rst_stall", 64'(req_stall), 64'hF);
      step();
      n_rst = 1'b1;
      check("mr_out_valid", 64'(out_valid), 0);
      check("mr_inflight", 64'(inflight), 0);
      check("mr_busy", 64'(busy), 0);
      check("mr_err", 64'(err_underflow), 0);
      ds_stall = 1'b0; #1;
      check("mr_restart_stall", 64'(req_stall), 64'hE);
      push(0); step();
      check("mr_restart_src", 64'(out_src), 0);
      check("mr_restart_inflight", 64'(inflight), 1);
      req_valid = '0;
      step(); step();
      check("sb_empty", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scpad_req_arb.md
SCPAD_REQ_ARB -- requirements
Module: scpad_req_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one scratchpad request port (2..8).
REQ-002 SHALL have parameter REQ_W, default 64: width of one packed request (rd_req_t/wr_req_t from scpad_types_pkg).
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum granted-but-uncompleted requests (1..15); CNT_W = $clog2(MAX_OUT+1).
REQ-004 SHALL have port clk  in  1  clock; single clock domain, all state updates on its rising edge.
REQ-005 SHALL have port n_rst  in  1  reset; synchronous and active-low.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester request valid; held high with stable data while stalled.
REQ-007 SHALL have port req_data  in  N_REQ*REQ_W  per-requester request; slice i = bits [i*REQ_W +: REQ_W].
REQ-008 SHALL have port req_stall  out  N_REQ  per-requester stall; request i is accepted in a cycle where req_valid[i]=1 and req_stall[i]=0.
REQ-009 SHALL have port out_valid  out  1  registered request valid toward scratchpad head.
REQ-010 SHALL have port out_req  out  REQ_W  registered request toward scratchpad head.
REQ-011 SHALL have port out_src  out  $clog2(N_REQ)  index of the requester that owns out_req.
REQ-012 SHALL have port ds_stall  in  1  downstream stall; out_valid is consumed in a cycle with out_valid=1 and ds_stall=0.
REQ-013 SHALL have port resp_done  in  1  one-cycle pulse: one outstanding request completed.
REQ-014 SHALL have port inflight  out  CNT_W  current outstanding count.
REQ-015 SHALL have port busy  out  1  out_valid | (inflight != 0).
REQ-016 SHALL have port err_underflow  out  1  sticky flag: resp_done seen while inflight = 0.

Function
REQ-017 SHALL compute slot_free = !out_valid | !ds_stall, and can_grant = slot_free & (inflight < MAX_OUT).
REQ-018 SHALL grant, when can_grant=1, exactly one valid requester: first index at or after rr_ptr in increasing order, wrapping N_REQ-1 -> 0.
REQ-019 SHALL grant nothing when can_grant=0 or no req_valid bit is set.
REQ-020 SHALL drive req_stall[i] = req_valid[i] & ~grant[i], combinationally in the same cycle.
REQ-021 SHALL, on grant to i, load out_req <= req_data slice i, out_src <= i and out_valid <= 1 on the next edge (1-cycle grant-to-output latency).
REQ-022 SHALL clear out_valid on an edge where out_valid was consumed and no new grant occurs.
REQ-023 SHALL hold out_valid, out_req and out_src stable while out_valid=1 and ds_stall=1.
REQ-024 SHALL allow back-to-back issue: consumption and a new grant in the same cycle keep out_valid=1 with the new request.
REQ-025 SHALL update rr_ptr <= (i+1) mod N_REQ on grant to i; rr_ptr is unchanged in cycles without a grant.
REQ-026 SHALL increment inflight on grant and decrement it on resp_done.
REQ-027 SHALL leave inflight unchanged when grant and resp_done occur in the same cycle.
REQ-028 SHALL not forward same-cycle credit: at inflight = MAX_OUT with resp_done=1, no grant occurs that cycle.
REQ-029 SHALL ignore resp_done while inflight = 0 (count stays 0) and set err_underflow to 1 until reset.
REQ-030 SHALL not let ds_stall affect inflight; inflight counts granted requests, including the one held in the output register.
REQ-031 SHALL have no combinational path from ds_stall or resp_done to out_valid, out_req or out_src.

Reset
REQ-032 SHALL, on a clk edge with n_rst=0, set out_valid=0, out_req=0, out_src=0, rr_ptr=0, inflight=0 and err_underflow=0.
REQ-033 SHALL drive req_stall = req_valid & ~grant during reset with grant forced to 0, so every valid requester is stalled.
REQ-034 SHALL, on reset mid-operation, drop the held request and all outstanding credits, with no replay.

Verification
REQ-035 SHALL cover: N_REQ=4, all valid continuously, ds_stall=0, resp_done echoing each grant 1 cycle later -> grants 0,1,2,3,0,...; out_src follows 1 cycle behind each grant.
REQ-036 SHALL cover: req_valid=4'b1010, rr_ptr=2 -> grant 3, then 1, then 3; req_stall pattern 4'b0010, then 4'b1000, then 4'b0010.
REQ-037 SHALL cover: ds_stall=1 for 5 cycles with out_valid=1 -> out_req/out_src stable, no grant, all valid requesters stalled; on release, the new grant lands the next cycle with out_valid continuous.
REQ-038 SHALL cover: MAX_OUT=4, no resp_done -> 4 grants, then inflight=4 and all stalled; a resp_done at inflight=4 enables a grant only on the next cycle.
REQ-039 SHALL cover: simultaneous grant and resp_done at inflight=2 -> inflight stays 2; resp_done at inflight=0 -> inflight stays 0 and err_underflow=1 until reset.
REQ-040 SHALL cover: n_rst=0 for one cycle with out_valid=1 and inflight=3 -> next cycle out_valid=0, inflight=0, busy=0, and arbitration restarts at requester 0.
